// File: rtl/traffic_phase_seq.sv
// Traffic phase sequencer: cycles conflicting signal phases through
// GREEN -> YELLOW -> ALLRED on a 1 s tick. It also supports a night-flash
// mode, a hold mode, priority pre-emption and a writable duration table.
module traffic_phase_seq #(
  parameter int N_PHASE    = 4,
  parameter int CNT_W      = 11,
  parameter int GREEN_DEF  = 8,
  parameter int YELLOW_DEF = 3,
  parameter int CLEAR_DEF  = 1,
  localparam int PW        = (N_PHASE > 1) ? $clog2(N_PHASE) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [1:0]         mode,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [PW-1:0]      cfg_phase,
  input  logic [CNT_W-1:0]   cfg_data,
  input  logic               preempt_req,
  input  logic [PW-1:0]      preempt_phase,
  output logic               preempt_ack,
  output logic [N_PHASE-1:0] red,
  output logic [N_PHASE-1:0] yellow,
  output logic [N_PHASE-1:0] green,
  output logic [PW-1:0]      cur_phase,
  output logic [CNT_W-1:0]   remain,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_FLASH  = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  state_t             st, nxt_st;
  logic [PW-1:0]      nxt_phase, inc_phase, grn_phase, eff_phase, pend_phase, nxt_pend_phase;
  logic [CNT_W-1:0]   nxt_remain, clear_dur;
  logic               flash, nxt_flash, restart, nxt_restart, nxt_ack;
  logic               pend_vld, nxt_pend_vld, req_ok, eff_vld, expire;
  logic [N_PHASE-1:0] onehot, nxt_red, nxt_yellow, nxt_green;
  logic [CNT_W-1:0]   green_tbl  [N_PHASE];
  logic [CNT_W-1:0]   yellow_tbl [N_PHASE];

  // A zero duration would stall the countdown, so a loaded 0 runs as 1.
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // An incoming request overrides the latched one (last request wins) and
  // takes effect at the edge that samples it.
  assign req_ok    = preempt_req && (int'(preempt_phase) < N_PHASE);
  assign eff_vld   = req_ok || pend_vld;
  assign eff_phase = req_ok ? preempt_phase : pend_phase;
  assign expire    = tick && (remain <= CNT_W'(1));
  assign inc_phase = (cur_phase == PW'(N_PHASE - 1)) ? '0 : cur_phase + PW'(1);
  assign grn_phase = eff_vld ? eff_phase : (restart ? '0 : inc_phase);
  assign onehot    = N_PHASE'(1) << nxt_phase;
  assign state     = st;

  // Duration table: out-of-range phase or select 3 leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the table is a handful of flops, not a RAM, so it is reset to the
    // defaults. A real memory macro could not be cleared this way.
    if (!rst_n) begin
      for (int i = 0; i < N_PHASE; i++) begin
        green_tbl[i]  <= CNT_W'(GREEN_DEF);
        yellow_tbl[i] <= CNT_W'(YELLOW_DEF);
      end
      clear_dur <= CNT_W'(CLEAR_DEF);
    end else if (cfg_we && (int'(cfg_phase) < N_PHASE)) begin
      case (cfg_sel)
        2'd0:    green_tbl[cfg_phase]  <= cfg_data;
        2'd1:    yellow_tbl[cfg_phase] <= cfg_data;
        2'd2:    clear_dur             <= cfg_data;
        default: ;
      endcase
    end
  end

  // Next-state, countdown, pre-emption and lamp decode.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    nxt_st         = st;
    nxt_phase      = cur_phase;
    nxt_remain     = remain;
    nxt_flash      = flash;
    nxt_restart    = restart;
    nxt_ack        = 1'b0;
    nxt_pend_vld   = eff_vld;
    nxt_pend_phase = eff_phase;
    case (mode)
      2'b01: begin
        if (st != S_FLASH) begin
          nxt_st     = S_FLASH;
          nxt_remain = '0;
          nxt_flash  = 1'b1;
        end else if (tick) begin
          nxt_flash = ~flash;
        end
      end
      2'b00: begin
        case (st)
          S_FLASH: begin
            nxt_st      = S_ALLRED;
            nxt_phase   = '0;
            nxt_remain  = ld(clear_dur);
            nxt_flash   = 1'b0;
            nxt_restart = 1'b1;
          end
          S_GREEN: begin
            if (eff_vld && (eff_phase == cur_phase)) begin
              nxt_remain   = ld(green_tbl[cur_phase]);
              nxt_ack      = 1'b1;
              nxt_pend_vld = 1'b0;
            end else if (eff_vld || expire) begin
              nxt_st     = S_YELLOW;
              nxt_remain = ld(yellow_tbl[cur_phase]);
            end else if (tick) begin
              nxt_remain = remain - CNT_W'(1);
            end
          end
          S_YELLOW: begin
            if (expire) begin
              nxt_st     = S_ALLRED;
              nxt_remain = ld(clear_dur);
            end else if (tick) begin
              nxt_remain = remain - CNT_W'(1);
            end
          end
          default: begin
            if (expire) begin
              nxt_st      = S_GREEN;
              nxt_phase   = grn_phase;
              nxt_remain  = ld(green_tbl[grn_phase]);
              nxt_restart = 1'b0;
              if (eff_vld) begin
                nxt_ack      = 1'b1;
                nxt_pend_vld = 1'b0;
              end
            end else if (tick) begin
              nxt_remain = remain - CNT_W'(1);
            end
          end
        endcase
      end
      default: ;
    endcase

    nxt_red    = '1;
    nxt_yellow = '0;
    nxt_green  = '0;
    case (nxt_st)
      S_FLASH: begin
        nxt_red    = '0;
        nxt_yellow = {N_PHASE{nxt_flash}};
      end
      S_GREEN: begin
        nxt_green = onehot;
        nxt_red   = ~onehot;
      end
      S_YELLOW: begin
        nxt_yellow = onehot;
        nxt_red    = ~onehot;
      end
      default: ;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so that every flop samples
    // the values from before the edge.
    if (!rst_n) begin
      st          <= S_ALLRED;
      cur_phase   <= '0;
      remain      <= CNT_W'(CLEAR_DEF);
      flash       <= 1'b0;
      restart     <= 1'b1;
      pend_vld    <= 1'b0;
      pend_phase  <= '0;
      preempt_ack <= 1'b0;
      red         <= '1;
      yellow      <= '0;
      green       <= '0;
    end else begin
      st          <= nxt_st;
      cur_phase   <= nxt_phase;
      remain      <= nxt_remain;
      flash       <= nxt_flash;
      restart     <= nxt_restart;
      pend_vld    <= nxt_pend_vld;
      pend_phase  <= nxt_pend_phase;
      preempt_ack <= nxt_ack;
      red         <= nxt_red;
      yellow      <= nxt_yellow;
      green       <= nxt_green;
    end
  end

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Directed bench for traffic_phase_seq with N_PHASE=4 and default durations.
module tb_traffic_phase_seq;

  localparam int N_PHASE = 4;
  localparam int CNT_W   = 11;
  localparam int PW      = 2;

  logic               clk = 1'b0;
  logic               rst_n, tick, cfg_we, preempt_req, preempt_ack;
  logic [1:0]         mode, cfg_sel, state;
  logic [PW-1:0]      cfg_phase, preempt_phase, cur_phase;
  logic [CNT_W-1:0]   cfg_data, remain;
  logic [N_PHASE-1:0] red, yellow, green;

  int checks = 0;
  int errors = 0;

  traffic_phase_seq #(.N_PHASE(N_PHASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_phase(cfg_phase), .cfg_data(cfg_data),
    .preempt_req(preempt_req), .preempt_phase(preempt_phase), .preempt_ack(preempt_ack),
    .red(red), .yellow(yellow), .green(green),
    .cur_phase(cur_phase), .remain(remain), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input int s, input int p, input int r);
    check({tag, ".state"}, 32'(state), s);
    check({tag, ".phase"}, 32'(cur_phase), p);
    check({tag, ".remain"}, 32'(remain), r);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick1();
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b1; tick = 1'b0; mode = 2'b00; cfg_we = 1'b0; cfg_sel = '0;
    cfg_phase = '0; cfg_data = '0; preempt_req = 1'b0; preempt_phase = '0;

    // Asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #2;
    check_st("reset", 3, 0, 1);
    check("reset.red", 32'(red), 4'hF);
    check("reset.yellow", 32'(yellow), 0);
    check("reset.green", 32'(green), 0);
    check("reset.ack", 32'(preempt_ack), 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check_st("idle_allred", 3, 0, 1);

    // Basic sequence
    tick1();
    check_st("green_p0", 1, 0, 8);
    check("green_p0.green", 32'(green), 4'b0001);
    check("green_p0.red", 32'(red), 4'b1110);
    cyc();
    ticks(7);
    check_st("green_p0_last", 1, 0, 1);
    ticks(1);
    check_st("yellow_p0", 2, 0, 3);
    check("yellow_p0.yellow", 32'(yellow), 4'b0001);
    check("yellow_p0.red", 32'(red), 4'b1110);
    ticks(3);
    check_st("allred_p0", 3, 0, 1);
    check("allred_p0.red", 32'(red), 4'hF);
    ticks(1);
    check_st("green_p1", 1, 1, 8);

    // Wrap from phase 3 to phase 0
    ticks(24);
    check_st("green_p3", 1, 3, 8);
    ticks(8);
    check_st("yellow_p3", 2, 3, 3);
    ticks(3);
    check_st("allred_p3", 3, 3, 1);
    ticks(1);
    check_st("wrap_green_p0", 1, 0, 8);
    check("wrap_green_p0.red", 32'(red), 4'b1110);

    // Pre-empt to phase 2 from GREEN p0
    ticks(3);
    check_st("pre_remain5", 1, 0, 5);
    preempt_req = 1'b1; preempt_phase = 2'd2;
    cyc();
    preempt_req = 1'b0;
    check_st("pre_yellow_p0", 2, 0, 3);
    check("pre_yellow_p0.ack", 32'(preempt_ack), 0);
    ticks(3);
    check_st("pre_allred", 3, 0, 1);
    check("pre_allred.ack", 32'(preempt_ack), 0);
    tick1();
    check_st("pre_green_p2", 1, 2, 8);
    check("pre_green_p2.ack", 32'(preempt_ack), 1);
    cyc();
    check("pre_ack_cleared", 32'(preempt_ack), 0);

    // Pre-empt for the phase already green reloads remain
    ticks(3);
    check_st("self_pre_before", 1, 2, 5);
    preempt_req = 1'b1; preempt_phase = 2'd2;
    cyc();
    preempt_req = 1'b0;
    check_st("self_pre_reload", 1, 2, 8);
    check("self_pre.ack", 32'(preempt_ack), 1);
    cyc();
    check("self_pre_ack_cleared", 32'(preempt_ack), 0);

    // Tick expiry and pre-empt in the same cycle
    ticks(7);
    check_st("same_cycle_before", 1, 2, 1);
    tick = 1'b1; preempt_req = 1'b1; preempt_phase = 2'd0;
    cyc();
    tick = 1'b0; preempt_req = 1'b0;
    check_st("same_cycle_yellow", 2, 2, 3);
    ticks(3);
    tick1();
    check_st("same_cycle_green_p0", 1, 0, 8);
    check("same_cycle.ack", 32'(preempt_ack), 1);
    cyc();

    // Hold freezes the countdown but still latches pre-empts
    ticks(2);
    mode = 2'b10;
    ticks(3);
    check_st("hold_frozen", 1, 0, 6);
    preempt_req = 1'b1; preempt_phase = 2'd3;
    cyc();
    preempt_req = 1'b0;
    check_st("hold_latch", 1, 0, 6);
    mode = 2'b00;
    cyc();
    check_st("hold_resume_yellow", 2, 0, 3);
    ticks(3);
    tick1();
    check_st("hold_pre_green_p3", 1, 3, 8);
    check("hold_pre.ack", 32'(preempt_ack), 1);
    cyc();

    // Night flash from GREEN p1
    ticks(24);
    check_st("flash_pre_green_p1", 1, 1, 8);
    mode = 2'b01;
    cyc();
    check("flash.state", 32'(state), 0);
    check("flash.remain", 32'(remain), 0);
    check("flash.yellow_on", 32'(yellow), 4'hF);
    check("flash.red", 32'(red), 0);
    check("flash.green", 32'(green), 0);
    ticks(1);
    check("flash.yellow_off", 32'(yellow), 0);
    ticks(1);
    check("flash.yellow_on2", 32'(yellow), 4'hF);
    mode = 2'b00;
    cyc();
    check_st("flash_exit_allred", 3, 0, 1);
    check("flash_exit.red", 32'(red), 4'hF);
    ticks(1);
    check_st("flash_exit_green_p0", 1, 0, 8);

    // Table writes take effect at the next load only
    ticks(12);
    ticks(1);
    check_st("cfg_before", 1, 1, 7);
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_phase = 2'd1; cfg_data = 11'd2;
    cyc();
    cfg_sel = 2'd1; cfg_phase = 2'd2; cfg_data = 11'd0;
    cyc();
    cfg_sel = 2'd3; cfg_phase = 2'd0; cfg_data = 11'd5;
    cyc();
    cfg_we = 1'b0;
    check_st("cfg_running_unchanged", 1, 1, 7);
    ticks(7);
    check_st("cfg_yellow_p1", 2, 1, 3);
    ticks(4);
    check_st("cfg_green_p2", 1, 2, 8);
    ticks(8);
    check_st("cfg_yellow_p2_zero", 2, 2, 1);
    ticks(1);
    check_st("cfg_allred_after_p2", 3, 2, 1);
    ticks(1);
    ticks(12);
    check_st("cfg_green_p0", 1, 0, 8);
    ticks(12);
    check_st("cfg_green_p1_short", 1, 1, 2);
    ticks(2);
    check_st("cfg_yellow_p1_after", 2, 1, 3);

    // Reset in YELLOW p2 while holding
    ticks(4);
    ticks(8);
    check_st("rst_pre_yellow_p2", 2, 2, 1);
    mode = 2'b10;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check_st("rst_mid", 3, 0, 1);
    check("rst_mid.red", 32'(red), 4'hF);
    check("rst_mid.yellow", 32'(yellow), 0);
    cyc();
    rst_n = 1'b1; mode = 2'b00;
    cyc();
    check_st("rst_release", 3, 0, 1);
    tick1();
    check_st("rst_green_p0", 1, 0, 8);
    cyc();
    ticks(12);
    check_st("rst_table_green_p1", 1, 1, 8);
    ticks(12);
    ticks(8);
    check_st("rst_table_yellow_p2", 2, 2, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_seq.md
TRAFFIC_PHASE_SEQ -- requirements
Module: traffic_phase_seq

Interface
REQ-001 SHALL have parameter N_PHASE, default 4, number of conflicting signal phases (2..8).
REQ-002 SHALL have parameter CNT_W, default 11, width of every duration and countdown value.
REQ-003 SHALL have parameters GREEN_DEF 8, YELLOW_DEF 3, CLEAR_DEF 1, reset durations in ticks.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick  input  1  one-clk-wide 1 s time-base pulse.
REQ-007 SHALL have port mode  input  2  00 run, 01 night flash, 10/11 hold.
REQ-008 SHALL have ports cfg_we (1), cfg_sel (2: 0 green, 1 yellow, 2 clear, 3 ignored), cfg_phase ($clog2(N_PHASE)), cfg_data (CNT_W), all inputs, duration-table write.
REQ-009 SHALL have ports preempt_req (1) and preempt_phase ($clog2(N_PHASE)), inputs, priority request for a phase.
REQ-010 SHALL have port preempt_ack  output  1  one-clk pulse when the requested green starts.
REQ-011 SHALL have ports red, yellow, green  output  N_PHASE each  one lamp bit per phase.
REQ-012 SHALL have ports cur_phase ($clog2(N_PHASE)), remain (CNT_W), state (2: 0 FLASH, 1 GREEN, 2 YELLOW, 3 ALLRED), all outputs, registered.

Function
REQ-013 SHALL implement states FLASH, GREEN, YELLOW, ALLRED; each state entry loads remain with its duration (green/yellow per cur_phase, clear global); loaded value 0 SHALL be treated as 1.
REQ-014 SHALL, in run mode, decrement remain on each tick; tick with remain==1 SHALL transition at that same edge and load the next duration.
REQ-015 SHALL sequence GREEN(p) -> YELLOW(p) -> ALLRED -> GREEN(next); next = pending preempt target if one is latched, else (p+1) wrapping N_PHASE-1 -> 0.
REQ-016 SHALL drive lamps: GREEN green[cur]=1; YELLOW yellow[cur]=1; all other phases red=1; ALLRED red all ones; FLASH red=green=0, yellow all equal to flash bit.
REQ-017 SHALL, in hold mode, freeze state, remain and lamps; ticks ignored; preempt requests still latched.
REQ-018 SHALL, when mode becomes 01, enter FLASH on the next edge from any state; remain=0; flash bit toggles on each tick, starting at 1 on entry.
REQ-019 SHALL, on mode leaving 01 to run, go FLASH -> ALLRED (clear duration) then GREEN phase 0 (or pending preempt target); hold from FLASH keeps FLASH.
REQ-020 SHALL latch preempt_req with preempt_phase (last request wins); preempt_phase >= N_PHASE ignored.
REQ-021 SHALL, on preempt latched in GREEN of another phase in run mode, go to YELLOW of cur_phase on the next edge regardless of remain.
REQ-022 SHALL, on preempt for the phase currently green, reload remain with that phase's green duration, pulse preempt_ack next cycle, clear pending.
REQ-023 SHALL pulse preempt_ack for exactly one clk on entry to GREEN of the latched target and clear the pending flag at that edge.
REQ-024 SHALL treat tick expiry and preempt in the same GREEN cycle as a single YELLOW entry with the target latched.
REQ-025 SHALL write cfg_data into the table entry on cfg_we; writes take effect at the next load only, never alter a running remain; cfg_phase >= N_PHASE or cfg_sel==3 ignored.
REQ-026 SHALL keep all arithmetic CNT_W bits unsigned; remain never decrements below 1 in-state.

Reset
REQ-027 SHALL on rst_n low immediately set state ALLRED, cur_phase 0, remain CLEAR_DEF, red all ones, yellow/green 0, preempt_ack 0, pending cleared, flash bit 0, table to defaults.
REQ-028 SHALL after reset release in run mode enter GREEN phase 0 after CLEAR_DEF ticks.

Verification (N_PHASE=4, defaults)
REQ-029 Reset, mode 00, ticks -> tick1 GREEN p0 remain 8, 8 ticks later YELLOW p0 remain 3, 3 ticks ALLRED remain 1, 1 tick GREEN p1.
REQ-030 Run to GREEN p3, expire -> YELLOW p3, ALLRED, GREEN p0 (wrap); red=1110 during GREEN p0.
REQ-031 In GREEN p0 remain 5 pulse preempt_req phase 2 -> next edge YELLOW p0 remain 3, ALLRED, GREEN p2 with single-cycle preempt_ack at entry.
REQ-032 mode 01 in GREEN p1 -> next edge FLASH, yellow 1111/0000 alternating per tick; mode 00 -> ALLRED 1 tick, GREEN p0.
REQ-033 During GREEN p1 write green p1=2 and yellow p2=0 -> current green unchanged; next p1 green lasts 2 ticks; p2 yellow lasts 1 tick.
REQ-034 rst_n low mid YELLOW p2 with mode 10 -> same-cycle ALLRED, red 1111, remain 1; release then mode 00 resumes at REQ-028.
